// File: rtl/lcd_pattern_gen.sv
// rtl/lcd_pattern_gen.sv - multi-channel periodic test-pattern source streaming to LCDCON
module lcd_pattern_gen #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int CH_BITS    = 2,
  parameter int PERIOD_LOG = 26
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    step,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                pause,
  input  logic                ready,
  output logic [WIDTH-1:0]    send_data,
  output logic [CH_BITS-1:0]  send_ch,
  output logic                we,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] M_INC  = 2'd0;
  localparam logic [1:0] M_DEC  = 2'd1;
  localparam logic [1:0] M_ROTL = 2'd2;

  logic [PERIOD_LOG-1:0] cnt_q;
  logic                  tick_q;
  logic [WIDTH-1:0]      val_q [CHANNELS];
  logic [WIDTH-1:0]      val_d [CHANNELS];
  logic [CHANNELS-1:0]   pending_q, pending_d;
  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [CH_BITS-1:0]    ch_q, ch_d;
  logic [15:0]           drop_q, drop_d;

  logic                  upd;
  logic [CHANNELS-1:0]   upd_mask;
  logic                  issue;
  logic [CH_BITS-1:0]    issue_ch;
  logic [WIDTH-1:0]      issue_data;
  logic [CHANNELS-1:0]   issue_mask;
  logic [CHANNELS-1:0]   pend_left;
  logic [CHANNELS-1:0]   drop_mask;
  logic [4:0]            drop_n;
  logic [16:0]           drop_sum;

  assign upd      = tick_q & ~pause;
  assign upd_mask = upd ? ch_en : '0;

  // Per-channel value update on an unpaused tick
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      val_d[c] = val_q[c];
      if (upd_mask[c]) begin
        case (mode)
          M_INC:   val_d[c] = val_q[c] + step;
          M_DEC:   val_d[c] = val_q[c] - step;
          M_ROTL:  val_d[c] = (val_q[c] == '0) ? WIDTH'(1)
                                               : {val_q[c][WIDTH-2:0], val_q[c][WIDTH-1]};
          default: val_d[c] = val_q[c];
        endcase
      end
    end
  end

  // Pick the lowest pending channel; data is taken after this cycle's update
  always_comb begin
    issue      = (state_q == S_IDLE) && (pending_q != '0) && ready;
    issue_ch   = '0;
    issue_data = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (pending_q[c]) begin
        issue_ch   = CH_BITS'(c);
        issue_data = val_d[c];
      end
    end
    issue_mask = issue ? (CHANNELS'(1) << issue_ch) : '0;
  end

  // Pending bookkeeping: a new update beats a same-cycle issue clear; unsent values count as drops
  always_comb begin
    pend_left = pending_q & ~issue_mask;
    drop_mask = pend_left & upd_mask;
    pending_d = pend_left | upd_mask;
    drop_n    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      drop_n = drop_n + 5'(drop_mask[c]);
    end
    drop_sum = {1'b0, drop_q} + 17'(drop_n);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Issue FSM: one-cycle write strobe followed by a guard cycle
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    data_d  = data_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_ISSUE;
          we_d    = 1'b1;
          data_d  = issue_data;
          ch_d    = issue_ch;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      pending_q <= '0;
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      data_q    <= '0;
      ch_q      <= '0;
      drop_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        val_q[c] <= '0;
      end
    end else begin
      cnt_q     <= cnt_q + PERIOD_LOG'(1);
      tick_q    <= (cnt_q == '0);
      pending_q <= pending_d;
      state_q   <= state_d;
      we_q      <= we_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      drop_q    <= drop_d;
      for (int c = 0; c < CHANNELS; c++) begin
        val_q[c] <= val_d[c];
      end
    end
  end

  assign send_data = data_q;
  assign send_ch   = ch_q;
  assign we        = we_q;
  assign drop_cnt  = drop_q;
  assign busy      = (pending_q != '0) || (state_q != S_IDLE);

endmodule
